// File: rtl/log_fp8_pkg.sv
// Shared E4M3 field widths, special encodings and the decoded-operand record
// used by the shared log2 exponent-extraction path.
package log_fp8_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;

  localparam logic [7:0] FP8_NAN  = 8'h7F;
  localparam logic [7:0] FP8_ZERO = 8'h00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
    logic             zero;
    logic             nan;
  } fp8_dec_t;

  function automatic fp8_dec_t fp8_decode(input logic [7:0] x);
    fp8_dec_t d;
    d.sign = x[7];
    d.expo = x[6:3];
    d.man  = x[2:0];
    d.zero = (d.expo == 4'd0) && (d.man == 3'd0);
    d.nan  = (d.expo == 4'hF) && (d.man == 3'h7);
    return d;
  endfunction

endpackage

// File: rtl/exp_to_fp8.sv
// ExpToFP8 converter: turns an E4M3 exponent (or a subnormal mantissa) into
// floor(log2|x|) and re-encodes that small integer as an E4M3 value.
module exp_to_fp8
  import log_fp8_pkg::*;
(
  input  logic             is_subnormal_i,
  input  logic [EXP_W-1:0] exp_val_i,
  output logic [7:0]       fp8_o
);

  logic [1:0] msb_s;
  logic [4:0] res_s;
  logic [3:0] mag_s;
  logic [6:0] body_s;

  // Subnormals scale as m * 2^-9, so the result is msb(m) - 9.
  always_comb begin
    msb_s = 2'd0;
    if (exp_val_i[2]) begin
      msb_s = 2'd2;
    end else if (exp_val_i[1]) begin
      msb_s = 2'd1;
    end else begin
      msb_s = 2'd0;
    end
    if (is_subnormal_i) begin
      res_s = {3'b000, msb_s} - 5'd9;
    end else begin
      res_s = {1'b0, exp_val_i} - 5'(BIAS);
    end
    mag_s = res_s[4] ? (4'd0 - res_s[3:0]) : res_s[3:0];
  end

  always_comb begin
    case (mag_s)
      4'd1:    body_s = 7'h38;
      4'd2:    body_s = 7'h40;
      4'd3:    body_s = 7'h44;
      4'd4:    body_s = 7'h48;
      4'd5:    body_s = 7'h4A;
      4'd6:    body_s = 7'h4C;
      4'd7:    body_s = 7'h4E;
      4'd8:    body_s = 7'h50;
      4'd9:    body_s = 7'h51;
      default: body_s = 7'h00;
    endcase
    if (mag_s == 4'd0) begin
      fp8_o = 8'h00;
    end else begin
      fp8_o = {res_s[4], body_s};
    end
  end

endmodule

// File: rtl/log_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is actually taken.
module log_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   cand_s;
  logic            found_s;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[ID_W-1:0]]) begin
        found_s   = 1'b1;
        gnt_idx_o = cand_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    gnt_oh_o[gnt_idx_o] = found_s;
    gnt_valid_o         = found_s;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found_s) begin
      ptr_d = (gnt_idx_o == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_o + ID_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/log_fp8_share_arb.sv
// One floor(log2|x|) E4M3 datapath shared by N_REQ requesters through a
// round-robin arbiter and a 2-stage elastic pipeline with a tagged output.
module log_fp8_share_arb
  import log_fp8_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [ID_W-1:0]    out_id,
  output logic               out_zero,
  output logic               out_nan,
  output logic               out_neg
);

  logic            s1_valid_q;
  fp8_dec_t        s1_op_q;
  logic [ID_W-1:0] s1_id_q;

  logic            s2_adv_s, s1_load_s, arb_en_s, accept_s;
  logic [N_REQ-1:0] gnt_oh_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic            gnt_valid_s;
  logic [7:0]      op_s, cvt_s, s2_data_d;
  fp8_dec_t        dec_s;
  logic            cvt_sub_s;
  logic [EXP_W-1:0] cvt_exp_s;

  assign s2_adv_s  = !out_valid || out_ready;
  assign s1_load_s = !s1_valid_q || s2_adv_s;
  assign arb_en_s  = s1_load_s && !rst;
  assign accept_s  = arb_en_s && gnt_valid_s;
  assign req_ready = accept_s ? gnt_oh_s : '0;
  assign op_s      = req_data[{gnt_idx_s, 3'b000} +: 8];
  assign dec_s     = fp8_decode(op_s);

  log_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_valid),
    .en_i       (arb_en_s),
    .gnt_oh_o   (gnt_oh_s),
    .gnt_idx_o  (gnt_idx_s),
    .gnt_valid_o(gnt_valid_s)
  );

  assign cvt_sub_s = (s1_op_q.expo == 4'd0);
  assign cvt_exp_s = cvt_sub_s ? {1'b0, s1_op_q.man} : s1_op_q.expo;

  exp_to_fp8 u_cvt (
    .is_subnormal_i(cvt_sub_s),
    .exp_val_i     (cvt_exp_s),
    .fp8_o         (cvt_s)
  );

  // NaN and zero bypass the converter with their canonical encodings.
  always_comb begin
    s2_data_d = cvt_s;
    if (s1_op_q.nan) begin
      s2_data_d = FP8_NAN;
    end else if (s1_op_q.zero) begin
      s2_data_d = FP8_ZERO;
    end else begin
      s2_data_d = cvt_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_id_q    <= '0;
    end else if (s1_load_s) begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_op_q <= dec_s;
        s1_id_q <= gnt_idx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_id    <= '0;
      out_zero  <= 1'b0;
      out_nan   <= 1'b0;
      out_neg   <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_data <= s2_data_d;
        out_id   <= s1_id_q;
        out_zero <= s1_op_q.zero;
        out_nan  <= s1_op_q.nan;
        out_neg  <= s1_op_q.sign & ~s1_op_q.nan;
      end
    end
  end

endmodule

// File: tb/tb_log_fp8_share_arb.sv
// Scoreboard bench for log_fp8_share_arb: per-lane operand queues feed the DUT,
// a negedge monitor predicts grants and results from an arithmetic log2 model.
module tb_log_fp8_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [7:0]     out_data;
  logic [IW-1:0]  out_id;
  logic           out_zero, out_nan, out_neg;

  log_fp8_share_arb #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_zero(out_zero),
    .out_nan(out_nan), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         id;
    logic       z, n, ng;
    int         t;
    bit         seen;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] lane_q[N][$];
  int         olog[$];
  int         glog[$];
  int         gtime[$];
  int         acc_cnt[N];
  int         n_cmp = 0, n_bad = 0;
  int         ptr_m = 0, neg_cnt = 0;
  logic [N-1:0] acc_vec = '0;
  bit         rnd_ready = 1'b0, fix_ready = 1'b1, bp_chk = 1'b0, lat_chk = 1'b0;
  bit         prev_stall = 1'b0, rst_prev = 1'b0;
  logic [7:0] held_d;
  logic [IW-1:0] held_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic real pow2(input int j);
    real r;
    r = 1.0;
    if (j >= 0) for (int i = 0; i < j; i++) r = r * 2.0;
    else for (int i = 0; i < -j; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic [7:0] enc_int(input int k);
    int mag, p, man;
    logic [7:0] r;
    if (k == 0) return 8'h00;
    mag = (k < 0) ? -k : k;
    p = 0;
    while ((1 << (p + 1)) <= mag) p++;
    man = ((mag - (1 << p)) * 8) >> p;
    r[7]   = (k < 0);
    r[6:3] = 4'(p + 7);
    r[2:0] = 3'(man);
    return r;
  endfunction

  // Reference: evaluate |x| as a real, find floor(log2), re-encode as E4M3.
  function automatic void ref_model(input logic [7:0] x, output logic [7:0] d,
                                    output logic z, output logic n, output logic ng);
    int e, m, k;
    real v;
    e  = int'(x[6:3]);
    m  = int'(x[2:0]);
    n  = (e == 15) && (m == 7);
    z  = (e == 0) && (m == 0);
    ng = x[7] && !n;
    if (n) d = 8'h7F;
    else if (z) d = 8'h00;
    else begin
      v = (e == 0) ? m / 512.0 : ((8 + m) / 8.0) * pow2(e - 7);
      k = -20;
      for (int j = -10; j <= 9; j++) if (v >= pow2(j)) k = j;
      d = enc_int(k);
    end
  endfunction

  // Monitor: output scoreboard, hold stability, grant prediction, accept capture.
  always @(negedge clk) begin : mon
    int g_exp, g_act;
    logic [N-1:0] acc, exp_oh;
    exp_t it;
    neg_cnt++;
    if (rst) begin
      chk("ready_in_reset", req_ready, 0);
      sb.delete();
      ptr_m = 0;
      prev_stall = 1'b0;
      acc_vec = '0;
    end else begin
      if (rst_prev) begin
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_id", out_id, 0);
        chk("reset_flags", {out_zero, out_nan, out_neg}, 0);
      end
      if (prev_stall) begin
        chk("hold_data", out_data, held_d);
        chk("hold_id", out_id, held_id);
      end
      if (out_valid) begin
        if (sb.size() == 0) chk("no_expected_out", {31'b0, out_valid}, 0);
        else begin
          chk("data", out_data, sb[0].d);
          chk("id", out_id, sb[0].id);
          chk("flags", {out_zero, out_nan, out_neg}, {sb[0].z, sb[0].n, sb[0].ng});
          if (lat_chk && !sb[0].seen) chk("latency", neg_cnt - sb[0].t, 2);
          sb[0].seen = 1'b1;
          if (out_ready) begin
            olog.push_back(int'({out_zero, out_nan, out_neg, out_data}));
            void'(sb.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held_d  = out_data;
      held_id = out_id;

      g_exp = -1;
      for (int k = 0; k < N; k++)
        if (g_exp < 0 && req_valid[(ptr_m + k) % N]) g_exp = (ptr_m + k) % N;
      exp_oh = (g_exp >= 0) ? (N'(1) << g_exp) : '0;
      if (bp_chk) chk("bp_ready", req_ready, 0);
      else if (req_ready != 0 || (out_ready && req_valid != 0)) chk("grant", req_ready, exp_oh);

      acc = req_valid & req_ready;
      acc_vec = acc;
      if (acc != 0) begin
        g_act = 0;
        for (int k = 0; k < N; k++) if (acc[k]) g_act = k;
        ref_model(req_data[8*g_act +: 8], it.d, it.z, it.n, it.ng);
        it.id = g_act;
        it.t = neg_cnt;
        it.seen = 1'b0;
        sb.push_back(it);
        ptr_m = (g_act + 1) % N;
        acc_cnt[g_act]++;
        glog.push_back(g_act);
        gtime.push_back(neg_cnt);
      end
    end
    rst_prev = rst;
  end

  // Driver: each lane presents the head of its queue until it is accepted.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (acc_vec[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        req_valid[i] = (lane_q[i].size() > 0);
        req_data[8*i +: 8] = (lane_q[i].size() > 0) ? lane_q[i][0] : 8'h00;
      end
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || out_valid || (req_valid != 0);
    for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name);
    int b;
    b = 0;
    cycles(1);
    while (busy() && b < 3000) begin
      cycles(1);
      b++;
    end
    chk({"drain_timeout_", name}, {31'b0, (b >= 3000)}, 0);
  endtask

  initial begin : main
    int exp1[4];
    int exp2[4];
    int exps[4];
    exp1 = '{32'h000, 32'h040, 32'h0D1, 32'h050};
    exp2 = '{32'h400, 32'h500, 32'h27F, 32'h140};
    exps = '{3, 1, 3, 1};
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    lat_chk = 1'b1;
    glog.delete(); gtime.delete();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) lane_q[i].push_back(8'($urandom_range(0, 255)));
    drain("fair");
    for (int i = 0; i < N; i++) chk("fair_count", acc_cnt[i], 4);
    chk("fair_total", glog.size(), 16);
    if (glog.size() == 16) begin
      chk("fair_span", gtime[15] - gtime[0], 15);
      for (int k = 0; k < 16; k++) chk("fair_order", glog[k], k % 4);
    end

    olog.delete(); glog.delete();
    lane_q[0].push_back(8'h38); lane_q[0].push_back(8'h48);
    lane_q[0].push_back(8'h01); lane_q[0].push_back(8'h78);
    drain("single");
    chk("single_count", olog.size(), 4);
    if (olog.size() == 4) for (int k = 0; k < 4; k++) chk("single_result", olog[k], exp1[k]);

    olog.delete();
    lane_q[2].push_back(8'h00); lane_q[2].push_back(8'h80);
    lane_q[2].push_back(8'h7F); lane_q[2].push_back(8'hC8);
    lane_q[2].push_back(8'hFF); lane_q[2].push_back(8'h08);
    drain("specials");
    chk("specials_count", olog.size(), 6);
    if (olog.size() == 6) for (int k = 0; k < 4; k++) chk("specials_result", olog[k], exp2[k]);

    lane_q[1].push_back(8'h40);
    drain("skip_setup");
    glog.delete();
    lane_q[1].push_back(8'h50); lane_q[1].push_back(8'h51);
    lane_q[3].push_back(8'h52); lane_q[3].push_back(8'h53);
    drain("skip");
    chk("skip_count", glog.size(), 4);
    if (glog.size() == 4) for (int k = 0; k < 4; k++) chk("skip_order", glog[k], exps[k]);

    lat_chk = 1'b0;
    olog.delete();
    fix_ready = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) lane_q[i].push_back(8'($urandom_range(0, 255)));
    cycles(3);
    bp_chk = 1'b1;
    cycles(5);
    bp_chk = 1'b0;
    fix_ready = 1'b1;
    drain("backpressure");
    chk("bp_count", olog.size(), 12);

    rnd_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0 && lane_q[i].size() < 3)
          lane_q[i].push_back(8'($urandom_range(0, 255)));
      cycles(1);
    end
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    drain("random");

    fix_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) lane_q[i].push_back(8'($urandom_range(0, 255)));
    cycles(4);
    for (int i = 0; i < N; i++) lane_q[i].delete();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    fix_ready = 1'b1;
    cycles(10);
    chk("post_reset_idle", {31'b0, out_valid}, 0);
    glog.delete();
    for (int i = 0; i < N; i++) lane_q[i].push_back(8'h48);
    drain("post_reset");
    chk("post_reset_count", glog.size(), 4);
    if (glog.size() > 0) chk("post_reset_ptr", glog[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

endmodule
